// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: host loader (0) and compute engine (1).
// Round-robin on ties, beat-limited grants under contention, and per-requester read-valid return.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MAXBEAT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  localparam int              CW   = $clog2(MAXBEAT) + 1;
  localparam logic [CW-1:0]   MAXC = CW'(MAXBEAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          beat0_p0;
  logic          beat1_p0;
  logic          beat_p0;
  logic          rvld0_p1;
  logic          rvld1_p1;

  // Beat counter stops at MAXBEAT so an uncontended grant can run forever.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= MAXC)
      return MAXC;
    return c + CW'(1);
  endfunction

  // Stage p0: beat decode and memory port mux from the granted requester
  always_comb begin
    beat0_p0  = (state == GRANT0) && req0;
    beat1_p0  = (state == GRANT1) && req1;
    beat_p0   = beat0_p0 || beat1_p0;
    mem_en    = beat_p0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat0_p0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (beat1_p0) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign cnt_inc = sat_inc(cnt);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        // last==1 means requester 1 was served most recently, so 0 wins a tie
        if (req0 && (!req1 || last))
          nxt = GRANT0;
        else if (req1)
          nxt = GRANT1;
      end
      GRANT0: begin
        if (!req0)
          nxt = req1 ? GRANT1 : IDLE;
        else if (req1 && (cnt_inc == MAXC))
          nxt = GRANT1;
      end
      GRANT1: begin
        if (!req1)
          nxt = req0 ? GRANT0 : IDLE;
        else if (req0 && (cnt_inc == MAXC))
          nxt = GRANT0;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= nxt;
      gnt0  <= (nxt == GRANT0);
      gnt1  <= (nxt == GRANT1);
      if ((nxt != state) && (nxt != IDLE)) begin
        last <= (nxt == GRANT1);
        cnt  <= '0;
      end else if (beat_p0) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Stage p1: read return, tagged by the requester that issued the read beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld0_p1 <= 1'b0;
      rvld1_p1 <= 1'b0;
    end else begin
      rvld0_p1 <= beat0_p0 && !we0;
      rvld1_p1 <= beat1_p0 && !we1;
    end
  end

  assign rvalid0 = rvld0_p1;
  assign rvalid1 = rvld1_p1;
  assign rdata   = mem_rdata;
  assign busy    = gnt0 | gnt1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// an owner/beat-count reference model and a shadow memory.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;
  logic          rvalid0, rvalid1, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAXBEAT(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy)
  );

  // Memory attached to the port: one-cycle read latency
  logic [DW-1:0] seed_mem [256];
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_q;
  logic          load;
  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_mem[i];
    end else begin
      if (mem_en && !mem_we) rd_q <= mem[mem_addr];
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: who owns the port, how many beats it has had, pending reads
  int            owner;
  int            last_m;
  int            beats;
  bit            pv0, pv1;
  logic [DW-1:0] pdata;
  logic [DW-1:0] mm [256];

  int checks = 0;
  int errors = 0;

  logic          cap_gnt0, cap_gnt1, cap_en, cap_we, cap_rv0, cap_rv1, cap_busy;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    last_m = 1;
    beats  = 0;
    pv0    = 0;
    pv1    = 0;
  endtask

  task automatic enter(input int n);
    owner  = n;
    last_m = n;
    beats  = 0;
  endtask

  task automatic model_update();
    bit r_own, r_oth, b, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int o;
    o = owner;
    r_own = (o == 0) ? req0 : req1;
    r_oth = (o == 0) ? req1 : req0;
    b = (o >= 0) && r_own;
    w = (o == 0) ? we0 : we1;
    a = (o == 0) ? addr0 : addr1;
    d = (o == 0) ? wdata0 : wdata1;
    pv0 = b && (o == 0) && !w;
    pv1 = b && (o == 1) && !w;
    if (b && !w) pdata = mm[a];
    if (b && w) mm[a] = d;
    if (o < 0) begin
      if (req0 && req1) enter(last_m == 1 ? 0 : 1);
      else if (req0) enter(0);
      else if (req1) enter(1);
    end else if (!r_own) begin
      if (r_oth) enter(1 - o);
      else owner = -1;
    end else begin
      beats = (beats + 1 > MB) ? MB : beats + 1;
      if (beats >= MB && r_oth) enter(1 - o);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge
  task automatic step();
    logic          b, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    cap_gnt0 = gnt0; cap_gnt1 = gnt1; cap_en = mem_en; cap_we = mem_we;
    cap_addr = mem_addr; cap_rv0 = rvalid0; cap_rv1 = rvalid1; cap_rdata = rdata;
    cap_busy = busy;
    b = 0; ew = 0; ea = '0; ed = '0;
    if (owner == 0 && req0) begin b = 1; ew = we0; ea = addr0; ed = wdata0; end
    else if (owner == 1 && req1) begin b = 1; ew = we1; ea = addr1; ed = wdata1; end
    chk("gnt0", 32'(gnt0), 32'(owner == 0));
    chk("gnt1", 32'(gnt1), 32'(owner == 1));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("mem_en", 32'(mem_en), 32'(b));
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(ed));
    chk("rvalid0", 32'(rvalid0), 32'(pv0));
    chk("rvalid1", 32'(rvalid1), 32'(pv1));
    if (pv0 || pv1) chk("rdata", 32'(rdata), 32'(pdata));
    chk("gnt_excl", 32'(gnt0 & gnt1), 32'(0));
    chk("en_one_gnt", 32'(mem_en && !(gnt0 ^ gnt1)), 32'(0));
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) seed_mem[i] = DW'($urandom);
    seed_mem[5] = 16'hBEEF;
    for (int i = 0; i < 256; i++) mm[i] = seed_mem[i];
    pdata = '0;
    idle_inputs();
    load = 1;
    rst  = 1;
    model_reset();
    step();
    step();
    chk("rst_gnt0", 32'(cap_gnt0), 32'(0));
    chk("rst_gnt1", 32'(cap_gnt1), 32'(0));
    chk("rst_busy", 32'(cap_busy), 32'(0));
    chk("rst_rvalid0", 32'(cap_rv0), 32'(0));
    load = 0;
    rst  = 0;
    step();

    // req0 alone, three write beats
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'hA000;
    step();
    chk("w3_idle_gnt0", 32'(cap_gnt0), 32'(0));
    for (int k = 0; k < 3; k++) begin
      addr0 = 8'(8'h10 + k); wdata0 = 16'(16'hA000 + k);
      step();
      chk("w3_gnt0", 32'(cap_gnt0), 32'(1));
      chk("w3_we", 32'(cap_we), 32'(1));
      chk("w3_addr", 32'(cap_addr), 32'(8'h10 + k));
    end
    req0 = 0;
    step();
    chk("w3_drop_gnt0_held", 32'(cap_gnt0), 32'(1));
    chk("w3_drop_no_beat", 32'(cap_en), 32'(0));
    step();
    chk("w3_gnt0_low", 32'(cap_gnt0), 32'(0));

    // req1 read of address 5
    req1 = 1; we1 = 0; addr1 = 8'h05;
    step();
    step();
    chk("rd_gnt1", 32'(cap_gnt1), 32'(1));
    chk("rd_en", 32'(cap_en), 32'(1));
    req1 = 0;
    step();
    chk("rd_rvalid1", 32'(cap_rv1), 32'(1));
    chk("rd_rdata", 32'(cap_rdata), 32'(16'hBEEF));
    chk("rd_rvalid0", 32'(cap_rv0), 32'(0));
    step();

    // both requesting: 8 beats each with direct handover
    req0 = 1; we0 = 0; addr0 = 8'h20;
    req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 16'h1234;
    step();
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("rr_gnt0", 32'(cap_gnt0), 32'((c <= 8) || (c == 17)));
      chk("rr_gnt1", 32'(cap_gnt1), 32'((c >= 9) && (c <= 16)));
      if (c == 9) chk("rr_rvalid0_after_handover", 32'(cap_rv0), 32'(1));
    end
    idle_inputs();
    step();
    step();

    // req1 alone for 20 beats, then req0 arrives and takes over at once
    req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 16'h5555;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("long_gnt1", 32'(cap_gnt1), 32'(1));
    end
    req0 = 1; we0 = 1; addr0 = 8'h41; wdata0 = 16'h6666;
    step();
    step();
    chk("long_handover_gnt0", 32'(cap_gnt0), 32'(1));
    chk("long_handover_gnt1", 32'(cap_gnt1), 32'(0));
    idle_inputs();
    step();
    step();

    // reset pulsed while requester 1 has a read in flight
    req1 = 1; we1 = 0; addr1 = 8'h05;
    step();
    step();
    req0 = 1; we0 = 0; addr0 = 8'h06;
    rst = 1;
    model_reset();
    #1;
    chk("rst_mid_gnt1", 32'(gnt1), 32'(0));
    chk("rst_mid_rvalid1", 32'(rvalid1), 32'(0));
    step();
    rst = 0;
    step();
    chk("rst_rel_rvalid1", 32'(cap_rv1), 32'(0));
    step();
    chk("rst_rel_gnt0", 32'(cap_gnt0), 32'(1));
    chk("rst_rel_rvalid1_2", 32'(cap_rv1), 32'(0));
    idle_inputs();
    step();

    // randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      we0    = $urandom_range(0, 1) == 1;
      we1    = $urandom_range(0, 1) == 1;
      addr0  = AW'($urandom);
      addr1  = AW'($urandom);
      wdata0 = DW'($urandom);
      wdata1 = DW'($urandom);
      if (rst) begin
        rst = 0;
      end else if ($urandom_range(0, 249) == 0) begin
        rst = 1;
        model_reset();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
